uart_rx_ctrl: RTL and testbench

//  Sequencer and byte buffer between the UART receiver and the CPU memory-mapped

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_rx_ctrl.sv | 82 ++++++++
 tb/tb_uart_rx_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: sequencer state encoding and
// bit positions inside the receiver status word and the CPU read word.
`timescale 1ns/1ps
package uart_pkg;

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_CLEAR  = 2'd3;

   localparam int EMPTY_BIT    = 15;
   localparam int OVR_BIT      = 14;
   localparam int RX_READY_BIT = 15;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with an explicit occupancy counter and a combinational
// head read; a pop and a push in the same cycle both take effect, even when full.
`timescale 1ns/1ps
module sync_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              pop,
   output logic [WIDTH-1:0]  rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              push_do, pop_do;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign pop_do  = pop && !empty;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign push_do = push && (!full || pop_do);
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_do) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_do)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push_do, pop_do})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; zeroed pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push_do) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive sequencer: polls the UART receiver, buffers each byte in a FIFO,
// re-arms the receiver, and packs FIFO state into the CPU read word.
`timescale 1ns/1ps
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       rx_out,
   output logic              rx_clear,
   input  logic              rd_en,
   input  logic              ovr_clr,
   output logic [15:0]       out,
   output logic [ADDR_W:0]   count
);

   logic [1:0] state_q, state_d;
   logic       ovr_q, ovr_d;
   logic       push_req, ovr_set;
   logic       fifo_full, fifo_empty;
   logic [7:0] head_byte;
   logic       unused_rx;

   assign unused_rx = ^rx_out[14:8];
   assign push_req  = (state_q == ST_WAIT) && !rx_out[RX_READY_BIT];
   // A full FIFO is never empty, so any rd_en there is a real pop.
   assign ovr_set   = push_req && fifo_full && !rd_en;
   assign rx_clear  = (state_q == ST_INIT) || (state_q == ST_CLEAR);

   sync_fifo #(
      .WIDTH  (8),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_req),
      .wr_data (rx_out[7:0]),
      .pop     (rd_en),
      .rd_data (head_byte),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:   state_d = ST_SETTLE;
         ST_SETTLE: if (rx_out[RX_READY_BIT]) state_d = ST_WAIT;
         ST_WAIT:   if (!rx_out[RX_READY_BIT]) state_d = ST_CLEAR;
         ST_CLEAR:  state_d = ST_SETTLE;
      endcase
   end

   always_comb begin
      ovr_d = ovr_q;
      if (ovr_set)      ovr_d = 1'b1;
      else if (ovr_clr) ovr_d = 1'b0;
   end

   always_comb begin
      out            = '0;
      out[EMPTY_BIT] = fifo_empty;
      out[OVR_BIT]   = ovr_q;
      out[7:0]       = head_byte;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized scoreboard bench for uart_rx_ctrl: a receiver model feeds bytes,
// a queue-based reference FIFO predicts the CPU word, a monitor compares.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [15:0]       rx_out;
   logic              rx_clear;
   logic              rd_en;
   logic              ovr_clr;
   logic [15:0]       out;
   logic [ADDR_W:0]   count;

   // Stimulus-to-model handshake: the byte presented this cycle must be captured.
   logic              cap_valid;
   logic [7:0]        cap_byte;

   logic [7:0] exp_q [$];
   logic       exp_ovr;

   int vectors     = 0;
   int miscompares = 0;

   uart_rx_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_out   (rx_out),
      .rx_clear (rx_clear),
      .rd_en    (rd_en),
      .ovr_clr  (ovr_clr),
      .out      (out),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor and reference model: compare at the falling edge, then apply this cycle's effects.
   int         mon_sz;
   logic [7:0] mon_exp;
   logic       mon_pop;
   logic       mon_ovr_set;
   always @(negedge clk) begin
      if (!reset) begin
         mon_sz = exp_q.size();
         check("count", 32'(count), 32'(mon_sz));
         check("status", 32'(out[15:8]), 32'({(mon_sz == 0), exp_ovr, 6'b0}));
         mon_pop = rd_en && (mon_sz > 0);
         if (mon_pop) begin
            mon_exp = exp_q.pop_front();
            check("pop_data", 32'(out[7:0]), 32'(mon_exp));
         end else begin
            check("head", 32'(out[7:0]), (mon_sz > 0) ? 32'(exp_q[0]) : 32'h0);
         end
         mon_ovr_set = 1'b0;
         if (cap_valid) begin
            if (mon_sz < DEPTH || mon_pop) exp_q.push_back(cap_byte);
            else                           mon_ovr_set = 1'b1;
         end
         if (mon_ovr_set)  exp_ovr = 1'b1;
         else if (ovr_clr) exp_ovr = 1'b0;
      end
   end

   // Receiver model: present a byte while the controller waits, expect one clear pulse, then go idle.
   task automatic send_byte(input logic [7:0] b, input int extra_low, input logic rd, input logic clr);
      rx_out    = {8'h00, b};
      cap_valid = 1'b1;
      cap_byte  = b;
      rd_en     = rd;
      ovr_clr   = clr;
      check("clear_before", 32'(rx_clear), 32'h0);
      tick();
      cap_valid = 1'b0;
      rd_en     = 1'b0;
      ovr_clr   = 1'b0;
      check("clear_pulse", 32'(rx_clear), 32'h1);
      tick();
      check("clear_after", 32'(rx_clear), 32'h0);
      for (int i = 0; i < extra_low; i++) begin
         tick();
         check("clear_hold", 32'(rx_clear), 32'h0);
      end
      rx_out = 16'h8000;
      tick();
      tick();
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         rd_en = 1'b1;
         tick();
      end
      rd_en = 1'b0;
   endtask

   task automatic pulse_ovr_clr();
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
   endtask

   // Asserts reset between edges, holds it n cycles, releases and waits until the controller polls.
   task automatic apply_reset(input int n);
      #2;
      reset     = 1'b1;
      exp_q.delete();
      exp_ovr   = 1'b0;
      rx_out    = 16'h8000;
      rd_en     = 1'b0;
      ovr_clr   = 1'b0;
      cap_valid = 1'b0;
      #1;
      check("rst_async_clear", 32'(rx_clear), 32'h1);
      check("rst_count", 32'(count), 32'h0);
      check("rst_out", 32'(out), 32'h8000);
      for (int i = 0; i < n; i++) begin
         tick();
         check("rst_hold_clear", 32'(rx_clear), 32'h1);
      end
      reset = 1'b0;
      check("init_clear", 32'(rx_clear), 32'h1);
      tick();
      check("settle_clear", 32'(rx_clear), 32'h0);
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      int         op;

      reset     = 1'b1;
      rx_out    = 16'h8000;
      rd_en     = 1'b0;
      ovr_clr   = 1'b0;
      cap_valid = 1'b0;
      cap_byte  = 8'h00;
      exp_ovr   = 1'b0;
      tick();
      apply_reset(3);
      check("t1_out", 32'(out), 32'h8000);
      check("t1_count", 32'(count), 32'h0);

      send_byte(8'hA5, 1, 1'b0, 1'b0);
      check("t2_out", 32'(out), 32'h00A5);
      check("t2_count", 32'(count), 32'h1);
      pop_n(1);

      for (int i = 1; i <= 3; i++) send_byte(8'(i), 0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         check("t3_order", 32'(out[7:0]), 32'(i));
         pop_n(1);
      end
      check("t3_empty", 32'(out), 32'h8000);
      pop_n(1);
      check("t3_ignored", 32'(count), 32'h0);

      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
      check("t4_full", 32'(count), 32'(DEPTH));
      send_byte(8'hFF, 0, 1'b0, 1'b0);
      check("t4_ovr_set", 32'(out[14]), 32'h1);
      check("t4_dropped", 32'(count), 32'(DEPTH));
      pulse_ovr_clr();
      check("t4_ovr_clr", 32'(out[14]), 32'h0);
      send_byte(8'hFF, 0, 1'b1, 1'b0);
      check("t4_no_ovr", 32'(out[14]), 32'h0);
      check("t4_still_full", 32'(count), 32'(DEPTH));
      send_byte(8'h3C, 0, 1'b0, 1'b1);
      check("t4_set_wins", 32'(out[14]), 32'h1);
      pulse_ovr_clr();
      pop_n(DEPTH);
      check("t4_drained", 32'(out), 32'h8000);

      for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         send_byte(8'($urandom_range(0, 255)), 0, 1'b1, 1'b0);
         check("t5_count", 32'(count), 32'h5);
      end
      pop_n(5);

      for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
      check("t6_count7", 32'(count), 32'h7);
      rx_out    = 16'h005A;
      cap_valid = 1'b1;
      cap_byte  = 8'h5A;
      apply_reset(1);
      send_byte(8'hC3, 0, 1'b0, 1'b0);
      check("t6_recapture", 32'(out), 32'h00C3);
      pop_n(1);

      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 9));
         b  = 8'($urandom_range(0, 255));
         if (op < 6)      send_byte(b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                                    ($urandom_range(0, 7) == 0));
         else if (op < 9) pop_n(int'($urandom_range(1, 4)));
         else             pulse_ovr_clr();
      end
      pop_n(DEPTH + 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
